fir_coef_loader: RTL and testbench

Loads FIR tap coefficients into the filter's `w_N[TAPS]` weight port. Coefficients arrive one word per handshake into a shadow bank. After a complete set is received, the shadow bank is copied to the active bank in a single cycle, so the FIR filter never sees a partially updated coefficient set. The block sits between the control/CSR path and the FIR filter core.

---
 rtl/fir_pkg.sv | 12 +
 rtl/fir_coef_bank.sv | 38 +++
 rtl/fir_coef_loader.sv | 123 ++++++++++++
 tb/tb_fir_coef_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared state type and index-width helper for the FIR coefficient loader.
// FIR_COEF_CHECKSUM_EN adds the CHECK state used by the trailing checksum word.
package fir_pkg;
`ifdef FIR_COEF_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2, CHECK = 2'd3} fir_coef_state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2} fir_coef_state_t;
`endif
    function automatic int IDX_W(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: shadow bank written word by word, copied whole into the active bank on commit.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int TAPS       = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [IDX_W(TAPS)-1:0]   widx,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     commit,
    output logic [DATA_WIDTH-1:0]    w_N [TAPS]
);
    logic [DATA_WIDTH-1:0] shadow_q [TAPS];
    logic [DATA_WIDTH-1:0] shadow_d [TAPS];
    logic [DATA_WIDTH-1:0] active_q [TAPS];
    logic [DATA_WIDTH-1:0] active_d [TAPS];

    always_comb begin
        shadow_d = shadow_q;
        if (we) shadow_d[widx] = wdata;
        active_d = commit ? shadow_q : active_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign w_N = active_q;
endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: handshake-driven coefficient loader with atomic commit to the FIR weight port.
// FIR_COEF_CHECKSUM_EN enables a trailing XOR checksum word and the err pulse.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int TAPS       = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  abort,
    input  logic                  coef_valid,
    output logic                  coef_ready,
    input  logic [DATA_WIDTH-1:0] coef_data,
    output logic [DATA_WIDTH-1:0] w_N [TAPS],
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int IW = IDX_W(TAPS);

    fir_coef_state_t state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            we, commit, accept, last;
`ifdef FIR_COEF_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  err_q, err_d;
`endif

    // abort wins over a simultaneous handshake, so the word is never accepted
    assign accept = coef_valid && ready_q && !abort;
    assign last   = idx_q == IW'(TAPS - 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        we      = 1'b0;
        commit  = 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
        acc_d   = acc_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: if (load_start) begin
                state_d = LOAD;
                idx_d   = '0;
`ifdef FIR_COEF_CHECKSUM_EN
                acc_d   = '0;
`endif
            end
            LOAD: if (abort) state_d = IDLE;
            else if (accept) begin
                we    = 1'b1;
                idx_d = last ? '0 : idx_q + 1'b1;
`ifdef FIR_COEF_CHECKSUM_EN
                acc_d   = acc_q ^ coef_data;
                state_d = last ? CHECK : LOAD;
`else
                state_d = last ? COMMIT : LOAD;
`endif
            end
`ifdef FIR_COEF_CHECKSUM_EN
            CHECK: if (abort) state_d = IDLE;
            else if (accept) begin
                state_d = (coef_data == acc_q) ? COMMIT : IDLE;
                err_d   = coef_data != acc_q;
            end
`endif
            COMMIT: begin
                commit  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != IDLE) && (state_d != COMMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
            acc_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef FIR_COEF_CHECKSUM_EN
            acc_q   <= acc_d;
            err_q   <= err_d;
`endif
        end
    end

    fir_coef_bank #(.TAPS(TAPS), .DATA_WIDTH(DATA_WIDTH)) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .widx   (idx_q),
        .wdata  (coef_data),
        .commit (commit),
        .w_N    (w_N)
    );

    assign coef_ready = ready_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
`ifdef FIR_COEF_CHECKSUM_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif
endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: directed checks of load, backpressure, abort, reset, ignored start and checksum.
module tb_fir_coef_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        abort = 1'b0;
    logic        coef_valid = 1'b0;
    logic        coef_ready;
    logic [15:0] coef_data = '0;
    logic [15:0] w_N [4];
    logic        busy, done, err;
    int          total = 0;
    int          bad = 0;

    fir_coef_loader #(.TAPS(4), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .abort      (abort),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .w_N        (w_N),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] wv();
        return {w_N[3], w_N[2], w_N[1], w_N[0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        coef_valid = 1'b1;
        coef_data  = d;
        step();
        coef_valid = 1'b0;
    endtask

    task automatic tail(input logic [15:0] csum);
`ifdef FIR_COEF_CHECKSUM_EN
        send(csum);
`else
        chk("no_csum_word", {48'd0, csum}, {48'd0, csum});
`endif
    endtask

    task automatic load4(input logic [15:0] a, b, c, d);
        start();
        send(a); send(b); send(c); send(d);
        tail(a ^ b ^ c ^ d);
        step();
    endtask

    initial begin
        #2;
        chk("rst_w", wv(), 64'd0);
        chk("rst_ready", {63'd0, coef_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        step();
        rst = 1'b0;
        step();

        // plain load, back-to-back words
        start();
        chk("plain_ready", {63'd0, coef_ready}, 64'd1);
        chk("plain_busy", {63'd0, busy}, 64'd1);
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
`ifdef FIR_COEF_CHECKSUM_EN
        chk("csum_state_ready", {63'd0, coef_ready}, 64'd1);
        chk("csum_state_done", {63'd0, done}, 64'd0);
`endif
        tail(16'd4 ^ 16'd3 ^ 16'd2 ^ 16'd1);
        chk("commit_ready", {63'd0, coef_ready}, 64'd0);
        chk("commit_done_early", {63'd0, done}, 64'd0);
        chk("commit_w_old", wv(), 64'd0);
        step();
        chk("plain_done", {63'd0, done}, 64'd1);
        chk("plain_w", wv(), 64'h0004_0003_0002_0001);
        chk("plain_busy_end", {63'd0, busy}, 64'd0);
        chk("plain_err", {63'd0, err}, 64'd0);
        step();
        chk("done_pulse", {63'd0, done}, 64'd0);

        // backpressure gaps
        start();
        for (int i = 5; i <= 8; i++) begin
            send(16'(i));
            if (i < 8) begin
                step();
                chk("gap_w_hold", wv(), 64'h0004_0003_0002_0001);
                chk("gap_done", {63'd0, done}, 64'd0);
            end
        end
        tail(16'd5 ^ 16'd6 ^ 16'd7 ^ 16'd8);
        step();
        chk("gap_done_end", {63'd0, done}, 64'd1);
        chk("gap_w", wv(), 64'h0008_0007_0006_0005);

        // abort with a simultaneous handshake that must be dropped
        start();
        send(16'd9); send(16'd10);
        abort = 1'b1;
        send(16'hBB);
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ready", {63'd0, coef_ready}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        step();
        chk("abort_done2", {63'd0, done}, 64'd0);
        chk("abort_err", {63'd0, err}, 64'd0);
        chk("abort_w", wv(), 64'h0008_0007_0006_0005);
        load4(16'h11, 16'h22, 16'h33, 16'h44);
        chk("post_abort_done", {63'd0, done}, 64'd1);
        chk("post_abort_w", wv(), 64'h0044_0033_0022_0011);

        // start during LOAD is ignored; abort during COMMIT is ignored
        start();
        send(16'hA1); send(16'hA2);
        load_start = 1'b1;
        send(16'hA3);
        load_start = 1'b0;
        chk("ign_busy", {63'd0, busy}, 64'd1);
        send(16'hA4);
        tail(16'hA1 ^ 16'hA2 ^ 16'hA3 ^ 16'hA4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ign_done", {63'd0, done}, 64'd1);
        chk("ign_w", wv(), 64'h00A4_00A3_00A2_00A1);
        // restart accepted in the done cycle
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("restart_busy", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("restart_abort", {63'd0, busy}, 64'd0);

`ifdef FIR_COEF_CHECKSUM_EN
        load4(16'h0001, 16'h0002, 16'h0004, 16'h0008);
        chk("csum_ok_done", {63'd0, done}, 64'd1);
        chk("csum_ok_w", wv(), 64'h0008_0004_0002_0001);
        start();
        send(16'h0010); send(16'h0020); send(16'h0040); send(16'h0080);
        send(16'h00FE);
        chk("csum_bad_err", {63'd0, err}, 64'd1);
        chk("csum_bad_done", {63'd0, done}, 64'd0);
        chk("csum_bad_busy", {63'd0, busy}, 64'd0);
        step();
        chk("csum_err_pulse", {63'd0, err}, 64'd0);
        chk("csum_bad_w", wv(), 64'h0008_0004_0002_0001);
`endif

        // asynchronous reset mid-load clears the active bank
        start();
        send(16'h55); send(16'h66); send(16'h77);
        rst = 1'b1;
        #1;
        chk("arst_w", wv(), 64'd0);
        chk("arst_ready", {63'd0, coef_ready}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("arst_idle", {63'd0, busy}, 64'd0);
        load4(16'hC0, 16'hC1, 16'hC2, 16'hC3);
        chk("arst_reload_done", {63'd0, done}, 64'd1);
        chk("arst_reload_w", wv(), 64'h00C3_00C2_00C1_00C0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
